// File: rtl/bank_reader_if.sv
// ---------------------------------------------------------------------------
// bank_reader_if
// Purpose: bundles the request and the word stream of the bank reader.
// Ports / signals:
//   rd_start  request pulse (sampled by the reader only while idle)
//   rd_addr   first register of the request (0..13 valid)
//   rd_len    words requested (0 means 1, above 14 clamps to 14)
//   rd_ready  consumer accepts the word on offer
//   rd_data   registered word on offer
//   rd_valid  rd_data is valid
//   rd_last   word on offer is the final word of the burst
//   rd_err    one-cycle pulse for a rejected request
//   busy      reader is serving a burst
// Modports: master = requester/consumer side, slave = bank_reader side.
// ---------------------------------------------------------------------------
interface bank_reader_if;
  logic        rd_start;
  logic [3:0]  rd_addr;
  logic [3:0]  rd_len;
  logic        rd_ready;
  logic [15:0] rd_data;
  logic        rd_valid;
  logic        rd_last;
  logic        rd_err;
  logic        busy;

  modport master (
    output rd_start, rd_addr, rd_len, rd_ready,
    input  rd_data, rd_valid, rd_last, rd_err, busy
  );

  modport slave (
    input  rd_start, rd_addr, rd_len, rd_ready,
    output rd_data, rd_valid, rd_last, rd_err, busy
  );
endinterface

// File: rtl/bank_reader.sv
// ---------------------------------------------------------------------------
// bank_reader
// Purpose: serves single-word or burst reads of the 14 x 16-bit register bank
// onto a valid/ready stream. Each offered word is a snapshot taken when the
// previous word transferred (or at request acceptance for the first word).
// Ports:
//   clk        sole clock, rising edge
//   rst_n      asynchronous active-low reset
//   in0..in13  current contents of bank registers 0..13
//   rd         bank_reader_if.slave: request, stream and status signals
// ---------------------------------------------------------------------------
module bank_reader (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [15:0]   in0,
  input  logic [15:0]   in1,
  input  logic [15:0]   in2,
  input  logic [15:0]   in3,
  input  logic [15:0]   in4,
  input  logic [15:0]   in5,
  input  logic [15:0]   in6,
  input  logic [15:0]   in7,
  input  logic [15:0]   in8,
  input  logic [15:0]   in9,
  input  logic [15:0]   in10,
  input  logic [15:0]   in11,
  input  logic [15:0]   in12,
  input  logic [15:0]   in13,
  bank_reader_if.slave  rd
);

  typedef enum logic {IDLE, SEND} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cur_addr_q, cur_addr_d;
  logic [3:0]  remaining_q, remaining_d;
  logic [15:0] rd_data_q, rd_data_d;
  logic        rd_last_q, rd_last_d;
  logic        rd_err_q, rd_err_d;

  logic [3:0]  eff_len;
  logic [3:0]  next_addr;
  logic [3:0]  mux_addr;
  logic [15:0] mux_word;

  // Request length normalisation and wrapping successor address (13 -> 0).
  always_comb begin
    eff_len = rd.rd_len;
    if (rd.rd_len == 4'd0) begin
      eff_len = 4'd1;
    end else if (rd.rd_len > 4'd14) begin
      eff_len = 4'd14;
    end
    next_addr = (cur_addr_q == 4'd13) ? 4'd0 : cur_addr_q + 4'd1;
  end

  // One read mux serves both cases: the request address while idle, the
  // successor address while sending. Addresses 14/15 never reach a load.
  always_comb begin
    mux_addr = (state_q == IDLE) ? rd.rd_addr : next_addr;
    mux_word = 16'h0000;
    case (mux_addr)
      4'd0:    mux_word = in0;
      4'd1:    mux_word = in1;
      4'd2:    mux_word = in2;
      4'd3:    mux_word = in3;
      4'd4:    mux_word = in4;
      4'd5:    mux_word = in5;
      4'd6:    mux_word = in6;
      4'd7:    mux_word = in7;
      4'd8:    mux_word = in8;
      4'd9:    mux_word = in9;
      4'd10:   mux_word = in10;
      4'd11:   mux_word = in11;
      4'd12:   mux_word = in12;
      4'd13:   mux_word = in13;
      default: mux_word = 16'h0000;
    endcase
  end

  // Next-state logic. Everything holds by default, which is what gives the
  // stall behaviour; rd_err defaults low so it can only ever pulse.
  always_comb begin
    state_d     = state_q;
    cur_addr_d  = cur_addr_q;
    remaining_d = remaining_q;
    rd_data_d   = rd_data_q;
    rd_last_d   = rd_last_q;
    rd_err_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (rd.rd_start) begin
          if (rd.rd_addr <= 4'd13) begin
            cur_addr_d  = rd.rd_addr;
            remaining_d = eff_len;
            rd_data_d   = mux_word;
            rd_last_d   = (eff_len == 4'd1);
            state_d     = SEND;
          end else begin
            rd_err_d = 1'b1;
          end
        end
      end
      SEND: begin
        if (rd.rd_ready) begin
          if (remaining_q == 4'd1) begin
            remaining_d = 4'd0;
            rd_last_d   = 1'b0;
            state_d     = IDLE;
          end else begin
            cur_addr_d  = next_addr;
            remaining_d = remaining_q - 4'd1;
            rd_data_d   = mux_word;
            rd_last_d   = (remaining_q == 4'd2);
          end
        end
      end
    endcase
  end

  // State register; reset abandons any burst in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cur_addr_q  <= 4'd0;
      remaining_q <= 4'd0;
      rd_data_q   <= 16'h0000;
      rd_last_q   <= 1'b0;
      rd_err_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_addr_q  <= cur_addr_d;
      remaining_q <= remaining_d;
      rd_data_q   <= rd_data_d;
      rd_last_q   <= rd_last_d;
      rd_err_q    <= rd_err_d;
    end
  end

  assign rd.rd_data  = rd_data_q;
  assign rd.rd_last  = rd_last_q;
  assign rd.rd_err   = rd_err_q;
  assign rd.rd_valid = (state_q == SEND);
  assign rd.busy     = (state_q != IDLE);

endmodule

// File: tb/tb_bank_reader.sv
// ---------------------------------------------------------------------------
// tb_bank_reader
// Purpose: directed self-checking bench for bank_reader. Registers hold
// 16'hA000+K so every expected word is known by address.
// ---------------------------------------------------------------------------
module tb_bank_reader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [15:0] in_r [14];

  int checks = 0;
  int errors = 0;

  bank_reader_if bus();

  bank_reader dut (
    .clk  (clk),
    .rst_n(rst_n),
    .in0  (in_r[0]),
    .in1  (in_r[1]),
    .in2  (in_r[2]),
    .in3  (in_r[3]),
    .in4  (in_r[4]),
    .in5  (in_r[5]),
    .in6  (in_r[6]),
    .in7  (in_r[7]),
    .in8  (in_r[8]),
    .in9  (in_r[9]),
    .in10 (in_r[10]),
    .in11 (in_r[11]),
    .in12 (in_r[12]),
    .in13 (in_r[13]),
    .rd   (bus)
  );

  always #5 clk = ~clk;

  // Global time limit so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_req(input logic [3:0] addr, input logic [3:0] len);
    bus.rd_start = 1'b1;
    bus.rd_addr  = addr;
    bus.rd_len   = len;
    tick();
    bus.rd_start = 1'b0;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.rd_data, bus.rd_valid, bus.rd_last, bus.rd_err, bus.busy} !== 20'h0) begin
      errors++;
      $display("[TB] FAIL reset_outputs got data=%h v=%b l=%b e=%b b=%b required all 0",
               bus.rd_data, bus.rd_valid, bus.rd_last, bus.rd_err, bus.busy);
    end
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    start_req(4'd5, 4'd1);
    checks++;
    if ({bus.rd_valid, bus.rd_last, bus.busy} !== 3'b111 || bus.rd_data !== 16'hA005) begin
      errors++;
      $display("[TB] FAIL single_word got v=%b l=%b b=%b data=%h required 1 1 1 a005",
               bus.rd_valid, bus.rd_last, bus.busy, bus.rd_data);
    end
    tick();
    checks++;
    if ({bus.rd_valid, bus.rd_last, bus.busy} !== 3'b000) begin
      errors++;
      $display("[TB] FAIL single_end got v=%b l=%b b=%b required 0 0 0",
               bus.rd_valid, bus.rd_last, bus.busy);
    end
  endtask

  task automatic test_wrap();
    logic [15:0] exp_seq [4];
    exp_seq[0] = 16'hA00C;
    exp_seq[1] = 16'hA00D;
    exp_seq[2] = 16'hA000;
    exp_seq[3] = 16'hA001;
    start_req(4'd12, 4'd4);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (bus.rd_valid !== 1'b1 || bus.rd_data !== exp_seq[k] || bus.rd_last !== (k == 3)) begin
        errors++;
        $display("[TB] FAIL wrap_word k=%0d got v=%b data=%h l=%b required 1 %h %b",
                 k, bus.rd_valid, bus.rd_data, bus.rd_last, exp_seq[k], (k == 3));
      end
      tick();
    end
    checks++;
    if (bus.rd_valid !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL wrap_end got v=%b b=%b required 0 0", bus.rd_valid, bus.busy);
    end
  endtask

  task automatic test_backpressure();
    start_req(4'd0, 4'd3);
    checks++;
    if (bus.rd_data !== 16'hA000 || bus.rd_valid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL bp_word0 got data=%h v=%b required a000 1", bus.rd_data, bus.rd_valid);
    end
    tick();
    bus.rd_ready = 1'b0;
    in_r[1] = 16'h5555;
    for (int s = 0; s < 4; s++) begin
      checks++;
      if (bus.rd_data !== 16'hA001 || bus.rd_valid !== 1'b1 || bus.rd_last !== 1'b0) begin
        errors++;
        $display("[TB] FAIL bp_stall s=%0d got data=%h v=%b l=%b required a001 1 0",
                 s, bus.rd_data, bus.rd_valid, bus.rd_last);
      end
      if (s == 3) bus.rd_ready = 1'b1;
      tick();
    end
    checks++;
    if (bus.rd_data !== 16'hA002 || bus.rd_valid !== 1'b1 || bus.rd_last !== 1'b1) begin
      errors++;
      $display("[TB] FAIL bp_resume got data=%h v=%b l=%b required a002 1 1",
               bus.rd_data, bus.rd_valid, bus.rd_last);
    end
    tick();
    in_r[1] = 16'hA001;
    checks++;
    if (bus.rd_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL bp_end got v=%b required 0", bus.rd_valid);
    end
  endtask

  task automatic test_error();
    start_req(4'd14, 4'd2);
    checks++;
    if (bus.rd_err !== 1'b1 || bus.rd_valid !== 1'b0 || bus.busy !== 1'b0 || bus.rd_data !== 16'hA002) begin
      errors++;
      $display("[TB] FAIL err_pulse got e=%b v=%b b=%b data=%h required 1 0 0 a002",
               bus.rd_err, bus.rd_valid, bus.busy, bus.rd_data);
    end
    tick();
    checks++;
    if (bus.rd_err !== 1'b0 || bus.rd_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL err_clear got e=%b v=%b required 0 0", bus.rd_err, bus.rd_valid);
    end
  endtask

  task automatic test_len_zero();
    start_req(4'd3, 4'd0);
    checks++;
    if (bus.rd_data !== 16'hA003 || bus.rd_last !== 1'b1 || bus.rd_valid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL len0_word got data=%h l=%b v=%b required a003 1 1",
               bus.rd_data, bus.rd_last, bus.rd_valid);
    end
    tick();
    checks++;
    if (bus.rd_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL len0_end got v=%b required 0", bus.rd_valid);
    end
  endtask

  task automatic test_len_clamp();
    start_req(4'd0, 4'd15);
    for (int k = 0; k < 14; k++) begin
      checks++;
      if (bus.rd_valid !== 1'b1 || bus.rd_data !== 16'hA000 + 16'(k) || bus.rd_last !== (k == 13)) begin
        errors++;
        $display("[TB] FAIL clamp_word k=%0d got v=%b data=%h l=%b required 1 %h %b",
                 k, bus.rd_valid, bus.rd_data, bus.rd_last, 16'hA000 + 16'(k), (k == 13));
      end
      tick();
    end
    checks++;
    if (bus.rd_valid !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL clamp_end got v=%b b=%b required 0 0", bus.rd_valid, bus.busy);
    end
  endtask

  task automatic test_start_while_busy();
    start_req(4'd7, 4'd3);
    bus.rd_start = 1'b1;
    bus.rd_addr  = 4'd2;
    bus.rd_len   = 4'd1;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (bus.rd_data !== 16'hA007 + 16'(k) || bus.rd_err !== 1'b0 || bus.rd_last !== (k == 2)) begin
        errors++;
        $display("[TB] FAIL busy_word k=%0d got data=%h e=%b l=%b required %h 0 %b",
                 k, bus.rd_data, bus.rd_err, bus.rd_last, 16'hA007 + 16'(k), (k == 2));
      end
      if (k == 2) bus.rd_start = 1'b0;
      tick();
    end
    checks++;
    if (bus.rd_valid !== 1'b0 || bus.busy !== 1'b0 || bus.rd_err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL busy_end got v=%b b=%b e=%b required 0 0 0",
               bus.rd_valid, bus.busy, bus.rd_err);
    end
  endtask

  task automatic test_reset_midburst();
    start_req(4'd0, 4'd6);
    tick();
    tick();
    checks++;
    if (bus.rd_data !== 16'hA002 || bus.rd_valid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL mid_word2 got data=%h v=%b required a002 1", bus.rd_data, bus.rd_valid);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.rd_data, bus.rd_valid, bus.rd_last, bus.rd_err, bus.busy} !== 20'h0) begin
      errors++;
      $display("[TB] FAIL mid_reset got data=%h v=%b l=%b e=%b b=%b required all 0",
               bus.rd_data, bus.rd_valid, bus.rd_last, bus.rd_err, bus.busy);
    end
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    tick();
    checks++;
    if (bus.busy !== 1'b0 || bus.rd_valid !== 1'b0 || bus.rd_data !== 16'h0000) begin
      errors++;
      $display("[TB] FAIL post_reset got b=%b v=%b data=%h required 0 0 0000",
               bus.busy, bus.rd_valid, bus.rd_data);
    end
  endtask

  initial begin
    for (int k = 0; k < 14; k++) in_r[k] = 16'hA000 + 16'(k);
    bus.rd_start = 1'b0;
    bus.rd_addr  = 4'd0;
    bus.rd_len   = 4'd0;
    bus.rd_ready = 1'b1;

    test_reset();
    test_single();
    test_wrap();
    test_backpressure();
    test_error();
    test_len_zero();
    test_len_clamp();
    test_start_while_busy();
    test_reset_midburst();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
